// File: rtl/deco7seg_pkg.sv
// Shared definitions for 7-segment pattern decoding and capture.
// Contents: segment table (active-high, bit0=a .. bit6=g), capture FSM
// state encoding, and the decoder result type with its invalid encoding.
package deco7seg_pkg;

   // Segment pattern per hex value; entry 0 is the rightmost element.
   localparam logic [15:0][6:0] SEG_TABLE = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   typedef enum logic [1:0] {
      ESPERA    = 2'd0,
      CONTANDO  = 2'd1,
      CAPTURADO = 2'd2
   } estado_e;

   typedef struct packed {
      logic       valido;
      logic [3:0] valor;
   } codif_t;

   localparam codif_t CODIF_INVALIDO = '{valido: 1'b0, valor: 4'h0};

endpackage

// File: rtl/codif_7seg_binario.sv
// Combinational 7-segment pattern to hex encoder.
// Ports: i_Segmentos - active-high segment pattern (bit0=a .. bit6=g)
//        o_Codif_c   - {valido, valor}; CODIF_INVALIDO when unrecognised
module codif_7seg_binario
   import deco7seg_pkg::*;
(
   input  logic [6:0] i_Segmentos,
   output codif_t     o_Codif_c
);

   // Table search; the entries are unique so at most one matches.
   always_comb begin
      o_Codif_c = CODIF_INVALIDO;
      for (int v = 0; v < 16; v++) begin
         if (i_Segmentos == SEG_TABLE[4'(v)]) begin
            o_Codif_c = '{valido: 1'b1, valor: 4'(v)};
         end
      end
   end

endmodule

// File: rtl/captura_7seg_binario.sv
// Captures a multiplexed 7-segment display bus back into hex digits.
// Ports: i_Clk, i_Rst_n (sync, active-low), i_Segmentos (a..g),
//        i_Digitos (one-hot selects), o_Valor (4 bits per digit),
//        o_Digito (last captured index), o_Valido / o_Error / o_Trama pulses.
module captura_7seg_binario
   import deco7seg_pkg::*;
#(
   parameter int unsigned NUM_DIG     = 4,
   parameter int unsigned STABLE_CYC  = 4,
   parameter bit          ACTIVO_BAJO = 1'b0
) (
   input  logic                 i_Clk,
   input  logic                 i_Rst_n,
   input  logic [6:0]           i_Segmentos,
   input  logic [NUM_DIG-1:0]   i_Digitos,
   output logic [4*NUM_DIG-1:0] o_Valor,
   output logic [2:0]           o_Digito,
   output logic                 o_Valido,
   output logic                 o_Error,
   output logic                 o_Trama
);

   localparam int unsigned CNT_W = $clog2(STABLE_CYC + 1);
   localparam int unsigned VAL_W = 4 * NUM_DIG;

   logic [6:0]         seg_d, s_seg_q;
   logic [NUM_DIG-1:0] s_dig_q;
   logic [CNT_W-1:0]   cnt_d, cnt_q;
   estado_e            estado_d, estado_q;
   logic [VAL_W-1:0]   valor_d, valor_q;
   logic [2:0]         digito_d, digito_q, idx_c;
   logic [NUM_DIG-1:0] mask_d, mask_q, mask_set_c;
   logic               valido_q, error_q, trama_q;
   logic               captura_c, acierto_c, fallo_c, trama_c;
   codif_t             codif_c;

   assign seg_d = ACTIVO_BAJO ? ~i_Segmentos : i_Segmentos;

   codif_7seg_binario u_codif (
      .i_Segmentos (s_seg_q),
      .o_Codif_c   (codif_c)
   );

   // Run counter tracks how long the value entering the sample register
   // has been held, so it is valid in the same cycle as that sample.
   always_comb begin
      cnt_d = cnt_q;
      if (!$onehot(i_Digitos)) begin
         cnt_d = '0;
      end else if ({seg_d, i_Digitos} != {s_seg_q, s_dig_q}) begin
         cnt_d = CNT_W'(1);
      end else if (cnt_q < CNT_W'(STABLE_CYC)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // FSM state register
   always_ff @(posedge i_Clk) begin
      if (!i_Rst_n) estado_q <= ESPERA;
      else          estado_q <= estado_d;
   end

   // FSM next state; cnt_q==1 in CAPTURADO means the sample just changed.
   always_comb begin
      estado_d = estado_q;
      if (!$onehot(s_dig_q)) begin
         estado_d = ESPERA;
      end else begin
         unique case (estado_q)
            ESPERA:    estado_d = CONTANDO;
            CONTANDO:  if (cnt_q == CNT_W'(STABLE_CYC)) estado_d = CAPTURADO;
            CAPTURADO: if (cnt_q == CNT_W'(1)) estado_d = CONTANDO;
            default:   estado_d = ESPERA;
         endcase
      end
   end

   // FSM outputs: capture decision and next values of the capture registers
   always_comb begin
      idx_c = '0;
      for (int i = 0; i < NUM_DIG; i++) begin
         if (s_dig_q[i]) idx_c = 3'(i);
      end
      captura_c  = (estado_q == CONTANDO) && $onehot(s_dig_q) &&
                   (cnt_q == CNT_W'(STABLE_CYC));
      acierto_c  = captura_c && codif_c.valido;
      fallo_c    = captura_c && !codif_c.valido;
      mask_set_c = mask_q | s_dig_q;
      trama_c    = acierto_c && (&mask_set_c);
      valor_d    = valor_q;
      digito_d   = digito_q;
      mask_d     = mask_q;
      if (acierto_c) begin
         for (int i = 0; i < NUM_DIG; i++) begin
            if (s_dig_q[i]) valor_d[4*i +: 4] = codif_c.valor;
         end
         digito_d = idx_c;
         mask_d   = trama_c ? '0 : mask_set_c;
      end
   end

   // Sample register, run counter and capture registers
   always_ff @(posedge i_Clk) begin
      if (!i_Rst_n) begin
         s_seg_q  <= '0;
         s_dig_q  <= '0;
         cnt_q    <= '0;
         valor_q  <= '0;
         digito_q <= '0;
         mask_q   <= '0;
         valido_q <= 1'b0;
         error_q  <= 1'b0;
         trama_q  <= 1'b0;
      end else begin
         s_seg_q  <= seg_d;
         s_dig_q  <= i_Digitos;
         cnt_q    <= cnt_d;
         valor_q  <= valor_d;
         digito_q <= digito_d;
         mask_q   <= mask_d;
         valido_q <= acierto_c;
         error_q  <= fallo_c;
         trama_q  <= trama_c;
      end
   end

   assign o_Valor  = valor_q;
   assign o_Digito = digito_q;
   assign o_Valido = valido_q;
   assign o_Error  = error_q;
   assign o_Trama  = trama_q;

endmodule

// File: tb/tb_captura_7seg_binario.sv
// Directed bench for captura_7seg_binario (NUM_DIG=4, STABLE_CYC=4).
// Two instances: active-high segments (dut) and active-low segments (dut_b).
module tb_captura_7seg_binario;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [6:0]  seg, seg_b;
   logic [3:0]  dig, dig_b;
   logic [15:0] valor, valor_b;
   logic [2:0]  digito, digito_b;
   logic        valido, error, trama;
   logic        valido_b, error_b, trama_b;

   int checks = 0;
   int errors = 0;

   // per-window monitor state
   int edge_no, n_val, n_err, n_trama, n_tv, first_val, last_val, trama_edge;
   int n_val_b, first_val_b;

   always #5 clk = ~clk;

   captura_7seg_binario #(.NUM_DIG(4), .STABLE_CYC(4), .ACTIVO_BAJO(1'b0)) dut (
      .i_Clk(clk), .i_Rst_n(rst_n), .i_Segmentos(seg), .i_Digitos(dig),
      .o_Valor(valor), .o_Digito(digito), .o_Valido(valido),
      .o_Error(error), .o_Trama(trama)
   );

   captura_7seg_binario #(.NUM_DIG(4), .STABLE_CYC(4), .ACTIVO_BAJO(1'b1)) dut_b (
      .i_Clk(clk), .i_Rst_n(rst_n), .i_Segmentos(seg_b), .i_Digitos(dig_b),
      .o_Valor(valor_b), .o_Digito(digito_b), .o_Valido(valido_b),
      .o_Error(error_b), .o_Trama(trama_b)
   );

   task automatic clear_mon();
      edge_no = 0; n_val = 0; n_err = 0; n_trama = 0; n_tv = 0;
      first_val = 0; last_val = 0; trama_edge = 0;
      n_val_b = 0; first_val_b = 0;
   endtask

   // One clock edge, then observe outputs 1 time unit later.
   task automatic tick(input int n);
      for (int c = 0; c < n; c++) begin
         @(posedge clk);
         #1;
         edge_no++;
         if (valido) begin
            n_val++;
            last_val = edge_no;
            if (first_val == 0) first_val = edge_no;
         end
         if (error) n_err++;
         if (trama) begin
            n_trama++;
            trama_edge = edge_no;
         end
         if (trama && valido) n_tv++;
         if (valido_b) begin
            n_val_b++;
            if (first_val_b == 0) first_val_b = edge_no;
         end
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      dig = 4'b0000; seg = 7'h00; dig_b = 4'b0000; seg_b = 7'h00;
      tick(2);
      rst_n = 1'b1;
      tick(1);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      dig = 4'b0001; seg = 7'h06; dig_b = 4'b0001; seg_b = 7'h00;
      tick(3);
      checks++; if (valor !== 16'h0000) begin errors++; $display("FAIL reset_valor: got %h expected 0000", valor); end
      checks++; if (digito !== 3'd0) begin errors++; $display("FAIL reset_digito: got %0d expected 0", digito); end
      checks++; if ({valido, error, trama} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b expected 000", {valido, error, trama}); end
      checks++; if (valor_b !== 16'h0000) begin errors++; $display("FAIL reset_valor_b: got %h expected 0000", valor_b); end
      do_reset();
   endtask

   task automatic test_single_capture();
      do_reset();
      dig = 4'b0001; seg = 7'h3F;
      clear_mon();
      tick(8);
      checks++; if (n_val !== 1) begin errors++; $display("FAIL single_count: got %0d expected 1", n_val); end
      checks++; if (first_val !== 5) begin errors++; $display("FAIL single_latency: got edge %0d expected 5", first_val); end
      checks++; if (valor !== 16'h0000) begin errors++; $display("FAIL single_valor: got %h expected 0000", valor); end
      checks++; if (digito !== 3'd0) begin errors++; $display("FAIL single_digito: got %0d expected 0", digito); end
      checks++; if (n_trama !== 0 || n_err !== 0) begin errors++; $display("FAIL single_extra: got trama %0d error %0d expected 0 0", n_trama, n_err); end
   endtask

   task automatic test_full_frame();
      logic [6:0] pats [4];
      pats[0] = 7'h06; pats[1] = 7'h5B; pats[2] = 7'h4F; pats[3] = 7'h66;
      do_reset();
      clear_mon();
      for (int d = 0; d < 4; d++) begin
         dig = 4'b1000 >> d;
         seg = pats[d];
         tick(6);
      end
      checks++; if (n_val !== 4) begin errors++; $display("FAIL frame_count: got %0d expected 4", n_val); end
      checks++; if (valor !== 16'h1234) begin errors++; $display("FAIL frame_valor: got %h expected 1234", valor); end
      checks++; if (n_trama !== 1 || n_tv !== 1) begin errors++; $display("FAIL frame_trama: got %0d with_valid %0d expected 1 1", n_trama, n_tv); end
      checks++; if (trama_edge !== 23 || last_val !== 23) begin errors++; $display("FAIL frame_trama_edge: got trama %0d valid %0d expected 23 23", trama_edge, last_val); end
      checks++; if (digito !== 3'd0) begin errors++; $display("FAIL frame_digito: got %0d expected 0", digito); end
   endtask

   task automatic test_glitch();
      clear_mon();
      dig = 4'b0100; seg = 7'h7F; tick(3);
      seg = 7'h6F; tick(3);
      dig = 4'b0000; tick(4);
      checks++; if (n_val !== 0 || n_err !== 0) begin errors++; $display("FAIL glitch_pulses: got valid %0d error %0d expected 0 0", n_val, n_err); end
      checks++; if (valor !== 16'h1234) begin errors++; $display("FAIL glitch_valor: got %h expected 1234", valor); end
   endtask

   task automatic test_invalid();
      clear_mon();
      dig = 4'b0010; seg = 7'h00; tick(6);
      checks++; if (n_err !== 1 || n_val !== 0) begin errors++; $display("FAIL inv_error: got error %0d valid %0d expected 1 0", n_err, n_val); end
      checks++; if (valor !== 16'h1234 || digito !== 3'd0) begin errors++; $display("FAIL inv_hold: got %h/%0d expected 1234/0", valor, digito); end
      // mask left intact: frame closes only when digit 1 is captured last
      dig = 4'b1000; seg = 7'h7F; tick(6);
      dig = 4'b0100; seg = 7'h6F; tick(6);
      dig = 4'b0001; seg = 7'h77; tick(6);
      checks++; if (n_val !== 3 || n_trama !== 0) begin errors++; $display("FAIL inv_mask_partial: got valid %0d trama %0d expected 3 0", n_val, n_trama); end
      dig = 4'b0010; seg = 7'h7C; tick(6);
      checks++; if (n_trama !== 1 || n_tv !== 1) begin errors++; $display("FAIL inv_mask_frame: got trama %0d with_valid %0d expected 1 1", n_trama, n_tv); end
      checks++; if (valor !== 16'h89BA || digito !== 3'd1) begin errors++; $display("FAIL inv_valor: got %h/%0d expected 89ba/1", valor, digito); end
   endtask

   task automatic test_bad_selects();
      clear_mon();
      seg = 7'h3F;
      dig = 4'b0011; tick(10);
      dig = 4'b0000; tick(10);
      checks++; if (n_val !== 0 || n_err !== 0 || n_trama !== 0) begin errors++; $display("FAIL badsel_pulses: got %0d %0d %0d expected 0 0 0", n_val, n_err, n_trama); end
      checks++; if (valor !== 16'h89BA) begin errors++; $display("FAIL badsel_valor: got %h expected 89ba", valor); end
   endtask

   task automatic test_reset_mid_count();
      clear_mon();
      dig = 4'b0001; seg = 7'h79; dig_b = 4'b0001; seg_b = 7'h00;
      tick(2);
      rst_n = 1'b0;
      tick(1);
      checks++; if (n_val !== 0 || valor !== 16'h0000) begin errors++; $display("FAIL rstmid_clear: got valid %0d valor %h expected 0 0000", n_val, valor); end
      rst_n = 1'b1;
      clear_mon();
      tick(8);
      checks++; if (n_val !== 1 || first_val !== 5) begin errors++; $display("FAIL rstmid_latency: got %0d at edge %0d expected 1 at 5", n_val, first_val); end
      checks++; if (valor !== 16'h000E) begin errors++; $display("FAIL rstmid_valor: got %h expected 000e", valor); end
      checks++; if (n_val_b !== 1 || first_val_b !== 5) begin errors++; $display("FAIL lowact_latency: got %0d at edge %0d expected 1 at 5", n_val_b, first_val_b); end
      checks++; if (valor_b !== 16'h0008) begin errors++; $display("FAIL lowact_valor: got %h expected 0008", valor_b); end
   endtask

   initial begin
      rst_n = 1'b0;
      dig = '0; seg = '0; dig_b = '0; seg_b = '0;
      clear_mon();
      test_reset();
      test_single_capture();
      test_full_frame();
      test_glitch();
      test_invalid();
      test_bad_selects();
      test_reset_mid_count();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
